// File: rtl/host_cmd_engine_pkg.sv
// Shared constants for the host command engine: opcodes, header layout and FSM states.
// The host-side software model mirrors these values.
package host_cmd_engine_pkg;

    localparam logic [3:0] OP_WRITE = 4'h1;
    localparam logic [3:0] OP_READ  = 4'h2;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 12;
    localparam int LEN_W  = 12;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_ADDR,
        ST_WDATA,
        ST_WACK,
        ST_RHDR,
        ST_RDATA
    } state_t;

    function automatic logic [15:0] make_hdr(input logic [3:0] op, input logic [LEN_W-1:0] len);
        return {op, len};
    endfunction

endpackage

// File: rtl/host_cmd_engine.sv
// Host pipe endpoint: parses WRITE/READ packets from the rx stream, drives the memory bus
// and pushes acknowledge headers and read data onto the tx stream.
module host_cmd_engine
    import host_cmd_engine_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    output logic                  rx_ready,
    input  logic                  rx_valid,
    input  logic [15:0]           rx_data,
    input  logic                  tx_ready,
    output logic                  tx_valid,
    output logic [15:0]           tx_data,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wr_data,
    input  logic [15:0]           mem_rd_data,
    output logic                  err_opcode,
    output logic                  busy
);

    state_t                state, state_nxt;
    logic [3:0]            op_q;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      remaining;
    logic [LEN_W-1:0]      need;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  armed;
    logic                  inflight;
    logic                  rd_pend;
    logic                  rx_take;
    logic                  hdr_push;
    logic                  op_known;

    // A word only counts if it answers a request from the previous cycle; stray
    // words right after reset are dropped this way.
    assign rx_take  = rx_valid && inflight;
    assign op_known = (rx_data[OP_MSB:OP_LSB] == OP_WRITE) || (rx_data[OP_MSB:OP_LSB] == OP_READ);

    always_comb begin
        need = '0;
        case (state)
            ST_HDR, ST_ADDR: need = LEN_W'(1);
            ST_WDATA:        need = remaining;
            default:         need = '0;
        endcase
        rx_ready = armed && (need > LEN_W'(inflight));
    end

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_nxt  = state;
        mem_wr_en  = 1'b0;
        mem_rd_en  = 1'b0;
        err_opcode = 1'b0;
        hdr_push   = 1'b0;
        case (state)
            ST_HDR: begin
                if (rx_take) begin
                    if (op_known) state_nxt = ST_ADDR;
                    else          err_opcode = 1'b1;
                end
            end
            ST_ADDR: begin
                if (rx_take) begin
                    if (op_q == OP_WRITE) state_nxt = (len_q == '0) ? ST_WACK : ST_WDATA;
                    else                  state_nxt = ST_RHDR;
                end
            end
            ST_WDATA: begin
                if (rx_take) begin
                    mem_wr_en = 1'b1;
                    if (remaining == LEN_W'(1)) state_nxt = ST_WACK;
                end
            end
            ST_WACK: begin
                if (tx_ready) begin
                    hdr_push  = 1'b1;
                    state_nxt = ST_HDR;
                end
            end
            ST_RHDR: begin
                if (tx_ready) begin
                    hdr_push  = 1'b1;
                    state_nxt = (len_q == '0) ? ST_HDR : ST_RDATA;
                end
            end
            ST_RDATA: begin
                // Issue the next read only once the previous word has been captured.
                mem_rd_en = tx_ready && (remaining != '0) && !rd_pend;
                if ((remaining == '0) && !rd_pend) state_nxt = ST_HDR;
            end
            default: state_nxt = ST_HDR;
        endcase
    end

    assign mem_addr    = addr_q;
    assign mem_wr_data = mem_wr_en ? rx_data : 16'h0000;
    assign busy        = (state != ST_HDR);

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) state <= ST_HDR;
        else            state <= state_nxt;
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            armed     <= 1'b0;
            inflight  <= 1'b0;
            rd_pend   <= 1'b0;
            tx_valid  <= 1'b0;
            tx_data   <= 16'h0000;
            op_q      <= 4'h0;
            len_q     <= '0;
            addr_q    <= '0;
            remaining <= '0;
        end else begin
            armed    <= 1'b1;
            inflight <= rx_ready;
            rd_pend  <= mem_rd_en;
            tx_valid <= hdr_push || rd_pend;
            if (hdr_push)     tx_data <= make_hdr(op_q, len_q);
            else if (rd_pend) tx_data <= mem_rd_data;

            if ((state == ST_HDR) && rx_take) begin
                op_q  <= rx_data[OP_MSB:OP_LSB];
                len_q <= rx_data[LEN_W-1:0];
            end
            if ((state == ST_ADDR) && rx_take) begin
                addr_q    <= rx_data[ADDR_WIDTH-1:0];
                remaining <= len_q;
            end
            if (mem_wr_en || mem_rd_en) begin
                addr_q    <= addr_q + ADDR_WIDTH'(1);
                remaining <= remaining - LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_host_cmd_engine.sv
// Scoreboard bench: a 16-bit and a 4-bit address instance share the rx/tx stimulus,
// each with its own memory model and expected-result queues.
module tb_host_cmd_engine;

    typedef struct {
        logic [15:0] data;
        logic        is_rd;
    } tx_exp_t;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_exp_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        rx_valid;
    logic [15:0] rx_data;
    logic        tx_ready;

    logic        rx_ready16, tx_valid16, wr_en16, rd_en16, err16, busy16;
    logic [15:0] tx_data16, addr16, wr_data16, rd_data16;
    logic        rx_ready4, tx_valid4, wr_en4, rd_en4, err4, busy4;
    logic [15:0] tx_data4, wr_data4, rd_data4;
    logic [3:0]  addr4;

    logic [15:0] mem16 [0:65535];
    logic [15:0] mem4  [0:15];
    logic [15:0] shadow16 [logic [15:0]];
    logic [15:0] shadow4  [logic [3:0]];

    logic [15:0] rx_q [$];
    tx_exp_t     exp_tx16 [$];
    tx_exp_t     exp_tx4 [$];
    wr_exp_t     exp_wr16 [$];
    wr_exp_t     exp_wr4 [$];

    int n_vec = 0;
    int n_err = 0;
    int rd_unpushed = 0;
    int rd_pushes = 0;
    int wr_seen16 = 0;
    int err_cnt16 = 0;

    always #5 sys_clk = ~sys_clk;

    host_cmd_engine #(.ADDR_WIDTH(16)) dut16 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .rx_ready(rx_ready16), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_ready(tx_ready), .tx_valid(tx_valid16), .tx_data(tx_data16),
        .mem_wr_en(wr_en16), .mem_rd_en(rd_en16), .mem_addr(addr16),
        .mem_wr_data(wr_data16), .mem_rd_data(rd_data16),
        .err_opcode(err16), .busy(busy16)
    );

    host_cmd_engine #(.ADDR_WIDTH(4)) dut4 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .rx_ready(rx_ready4), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_ready(tx_ready), .tx_valid(tx_valid4), .tx_data(tx_data4),
        .mem_wr_en(wr_en4), .mem_rd_en(rd_en4), .mem_addr(addr4),
        .mem_wr_data(wr_data4), .mem_rd_data(rd_data4),
        .err_opcode(err4), .busy(busy4)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge sys_clk) begin
        if (wr_en16) mem16[addr16] <= wr_data16;
        if (rd_en16) rd_data16 <= mem16[addr16];
        if (wr_en4)  mem4[addr4] <= wr_data4;
        if (rd_en4)  rd_data4 <= mem4[addr4];
    end

    // Rx FIFO model: answers a request one cycle later, or randomly starves it.
    initial begin
        logic req;
        rx_valid = 1'b0;
        rx_data  = 16'h0000;
        forever begin
            @(negedge sys_clk);
            req = rx_ready16;
            @(posedge sys_clk);
            #1;
            if (req && (rx_q.size() > 0) && ($urandom_range(0, 3) != 0)) begin
                rx_valid = 1'b1;
                rx_data  = rx_q.pop_front();
            end else begin
                rx_valid = 1'b0;
                rx_data  = 16'($urandom);
            end
        end
    end

    always @(negedge sys_clk) begin
        tx_exp_t e;
        wr_exp_t w;
        if (tx_valid16) begin
            if (exp_tx16.size() == 0) check("tx16_extra", {15'b0, tx_valid16}, 16'h0000);
            else begin
                e = exp_tx16.pop_front();
                check("tx16", tx_data16, e.data);
                if (e.is_rd) begin
                    rd_pushes++;
                    rd_unpushed--;
                end
            end
        end
        if (tx_valid4) begin
            if (exp_tx4.size() == 0) check("tx4_extra", {15'b0, tx_valid4}, 16'h0000);
            else begin
                e = exp_tx4.pop_front();
                check("tx4", tx_data4, e.data);
            end
        end
        if (rd_en16) begin
            check("rd_outstanding", 16'(rd_unpushed), 16'h0000);
            rd_unpushed++;
        end
        if (!tx_ready) check("rd_stall", {15'b0, rd_en16}, 16'h0000);
        if (wr_en16) begin
            if (exp_wr16.size() == 0) check("wr16_extra", {15'b0, wr_en16}, 16'h0000);
            else begin
                w = exp_wr16.pop_front();
                check("wr16_addr", addr16, w.addr);
                check("wr16_data", wr_data16, w.data);
            end
            wr_seen16++;
        end
        if (wr_en4) begin
            if (exp_wr4.size() == 0) check("wr4_extra", {15'b0, wr_en4}, 16'h0000);
            else begin
                w = exp_wr4.pop_front();
                check("wr4_addr", {12'h000, addr4}, {12'h000, w.addr[3:0]});
                check("wr4_data", wr_data4, w.data);
            end
        end
        if (err16) err_cnt16++;
    end

    task automatic push_tx(input logic [15:0] d16, input logic [15:0] d4, input logic is_rd);
        tx_exp_t e;
        e.is_rd = is_rd;
        e.data  = d16;
        exp_tx16.push_back(e);
        e.data  = d4;
        exp_tx4.push_back(e);
    endtask

    task automatic send_write(input logic [15:0] a, input int n, input logic [15:0] base,
                              input logic [15:0] step);
        wr_exp_t w;
        logic [15:0] d;
        logic [15:0] hdr;
        hdr = {4'h1, 12'(n)};
        rx_q.push_back(hdr);
        rx_q.push_back(a);
        for (int i = 0; i < n; i++) begin
            d      = base + step * 16'(i);
            w.addr = a + 16'(i);
            w.data = d;
            rx_q.push_back(d);
            exp_wr16.push_back(w);
            exp_wr4.push_back(w);
            shadow16[w.addr]     = d;
            shadow4[w.addr[3:0]] = d;
        end
        push_tx(hdr, hdr, 1'b0);
    endtask

    task automatic send_read(input logic [15:0] a, input int n);
        logic [15:0] hdr;
        logic [15:0] ai;
        hdr = {4'h2, 12'(n)};
        rx_q.push_back(hdr);
        rx_q.push_back(a);
        push_tx(hdr, hdr, 1'b0);
        for (int i = 0; i < n; i++) begin
            ai = a + 16'(i);
            push_tx(shadow16[ai], shadow4[ai[3:0]], 1'b1);
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int c = 0; c < 3000; c++) begin
            if ((rx_q.size() + exp_tx16.size() + exp_tx4.size() + exp_wr16.size() + exp_wr4.size()) == 0) break;
            @(posedge sys_clk);
        end
        repeat (4) @(posedge sys_clk);
        check(tag, 16'(rx_q.size() + exp_tx16.size() + exp_tx4.size() + exp_wr16.size() + exp_wr4.size()),
              16'h0000);
        @(negedge sys_clk);
        check({tag, "_busy"}, {14'b0, busy16, busy4}, 16'h0000);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rx_ready"}, {15'b0, rx_ready16}, 16'h0000);
        check({tag, "_tx_valid"}, {15'b0, tx_valid16}, 16'h0000);
        check({tag, "_wr_en"},    {15'b0, wr_en16}, 16'h0000);
        check({tag, "_rd_en"},    {15'b0, rd_en16}, 16'h0000);
        check({tag, "_err"},      {15'b0, err16}, 16'h0000);
        check({tag, "_busy"},     {15'b0, busy16}, 16'h0000);
        check({tag, "_tx_data"},  tx_data16, 16'h0000);
        check({tag, "_addr"},     addr16, 16'h0000);
        check({tag, "_wr_data"},  wr_data16, 16'h0000);
        check({tag, "_dut4"}, {rx_ready4, tx_valid4, wr_en4, rd_en4, err4, busy4, 6'b0, addr4} | tx_data4 | wr_data4,
              16'h0000);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int start;
        sys_rst_n = 1'b0;
        tx_ready  = 1'b1;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check_zero("rst_init");
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;

        // 1: three-word write
        send_write(16'h0010, 3, 16'hAAAA, 16'h1111);
        wait_idle("t1_write");

        // 2: two-word read after preload
        send_write(16'h0020, 2, 16'h1234, 16'h4444);
        send_read(16'h0020, 2);
        wait_idle("t2_read");
        check("t2_rd_pushes", 16'(rd_pushes), 16'd2);

        // 3: unknown opcode followed by a valid write
        check("t3_err_before", 16'(err_cnt16), 16'd0);
        rx_q.push_back(16'h7000);
        send_write(16'h0005, 1, 16'hDEAD, 16'h0000);
        wait_idle("t3_err");
        check("t3_err_count", 16'(err_cnt16), 16'd1);

        // 4: four-word read with tx back-pressure mid-burst
        send_write(16'h0030, 4, 16'h0101, 16'h1010);
        wait_idle("t4_preload");
        start = rd_pushes;
        send_read(16'h0030, 4);
        for (int c = 0; c < 500 && rd_pushes < start + 1; c++) @(posedge sys_clk);
        check("t4_first_word", 16'(rd_pushes - start), 16'd1);
        @(posedge sys_clk);
        #1 tx_ready = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1 tx_ready = 1'b1;
        wait_idle("t4_stall");
        check("t4_rd_pushes", 16'(rd_pushes - start), 16'd4);

        // 5: address wrap on the narrow instance, zero-length packets
        send_write(16'h000F, 2, 16'h0001, 16'h0001);
        send_write(16'h0003, 0, 16'h0000, 16'h0000);
        send_read(16'h0005, 0);
        wait_idle("t5_wrap");
        check("t5_mem4_f", mem4[15], 16'h0001);
        check("t5_mem4_0", mem4[0], 16'h0002);

        // 6: reset in the middle of a write burst
        start = wr_seen16;
        send_write(16'h0040, 5, 16'h1001, 16'h0001);
        for (int c = 0; c < 500 && wr_seen16 < start + 2; c++) @(negedge sys_clk);
        check("t6_partial", 16'(wr_seen16 - start), 16'd2);
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b0;
        @(posedge sys_clk);
        #2;
        rx_q.delete();
        exp_tx16.delete();
        exp_tx4.delete();
        exp_wr16.delete();
        exp_wr4.delete();
        rd_unpushed = 0;
        @(negedge sys_clk);
        check_zero("t6_rst");
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        send_write(16'h0007, 1, 16'h0042, 16'h0000);
        wait_idle("t6_fresh");
        check("t6_mem16_7", mem16[7], 16'h0042);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
